// File: rtl/uart_tx_emitter.sv
// uart_tx_emitter: 8N1 serial transmitter with valid/ready byte intake.
// Registered outputs; back-to-back frames restart on the stop-bit boundary.
module uart_tx_emitter #(
    parameter int clk_freq_hz = 10_000_000,
    parameter int baud_rate   = 1_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_uart_tx
);
    localparam int DIV = (clk_freq_hz + baud_rate / 2) / baud_rate;
    localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [0:0] S_SEND = 1'b0;
    localparam logic [0:0] S_IDLE = 1'b1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_emitter: clocks per bit must be at least 2");
    end

    logic [0:0]    r_state;
    logic [7:0]    r_shift;
    logic [3:0]    r_bit;
    logic [BW-1:0] r_baud;
    logic          r_tx;
    logic          w_wrap;
    logic          w_last;
    logic          w_accept;

    assign w_wrap   = r_baud == BW'(DIV - 1);
    assign w_last   = r_state == S_SEND && w_wrap && r_bit == 4'd9;
    // A request on the final stop-bit edge starts the next frame with no idle gap
    assign w_accept = i_valid && (r_state == S_IDLE || w_last);
    assign o_ready   = r_state[0];
    assign o_uart_tx = r_tx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_tx    <= 1'b1;
        end else if (w_accept) begin
            r_state <= S_SEND;
            r_shift <= i_data;
            r_bit   <= '0;
            r_baud  <= '0;
            r_tx    <= 1'b0;
        end else if (r_state == S_SEND) begin
            if (w_last) begin
                r_state <= S_IDLE;
                r_bit   <= '0;
                r_baud  <= '0;
                r_tx    <= 1'b1;
            end else if (w_wrap) begin
                // Ones shift in behind the data so bit 8 emerges as the stop bit
                r_baud  <= '0;
                r_bit   <= r_bit + 4'd1;
                r_tx    <= r_shift[0];
                r_shift <= {1'b1, r_shift[7:1]};
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_emitter.sv
// tb_uart_tx_emitter: directed and random 8N1 frames checked cycle by cycle
// against a frame-position model of the serial line.
module tb_uart_tx_emitter;
    localparam int DIV   = 10;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       o_uart_tx;

    int         n_checks = 0;
    int         n_fail = 0;
    string      phase = "init";
    bit         m_busy = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_byte = 8'h00;

    uart_tx_emitter #(.clk_freq_hz(10_000_000), .baud_rate(1_000_000)) dut (
        .clk(clk),
        .resetn(resetn),
        .i_data(i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_uart_tx(o_uart_tx)
    );

    always #5 clk = ~clk;

    // Line level is the frame bit selected by elapsed clocks since acceptance
    function automatic logic exp_tx();
        logic [9:0] frame;
        if (!m_busy) return 1'b1;
        frame = {1'b1, m_byte, 1'b0};
        return frame[m_cnt / DIV];
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %b expected %b at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %0d expected %0d at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        i_valid = v;
        i_data  = d;
        @(posedge clk);
        if (!resetn) m_busy = 1'b0;
        else if (m_busy && m_cnt < FRAME - 1) m_cnt++;
        else if (v) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_byte = d;
        end else m_busy = 1'b0;
        #1;
        check("tx", o_uart_tx, exp_tx());
        check("ready", o_ready, !m_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic do_reset(input int hold);
        resetn = 1'b0;
        #1;
        m_busy = 1'b0;
        check("rst_tx_async", o_uart_tx, 1'b1);
        check("rst_ready_async", o_ready, 1'b1);
        for (int i = 0; i < hold; i++) step(1'b1, 8'($urandom));
        resetn = 1'b1;
    endtask

    initial begin
        int low;
        phase = "reset";
        #2;
        do_reset(5);
        idle(30);

        phase = "byte55";
        step(1'b1, 8'h55);
        low = 1;
        for (int i = 0; i < 150; i++) begin
            step(1'b0, 8'h00);
            if (o_ready === 1'b0) low++;
        end
        check_int("ready_low_clocks", low, FRAME);

        phase = "byteA3";
        step(1'b1, 8'hA3);
        idle(FRAME + 10);

        phase = "b2b";
        step(1'b1, 8'h00);
        for (int i = 1; i < FRAME; i++) step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        check("b2b_start", o_uart_tx, 1'b0);
        idle(FRAME + 10);

        phase = "ignored";
        step(1'b1, 8'h41);
        idle(36);
        step(1'b1, 8'h7E);
        idle(FRAME);

        phase = "midreset";
        step(1'b1, 8'h3C);
        idle(45);
        do_reset(2);
        idle(40);

        phase = "random";
        for (int i = 0; i < 1500; i++) step(($urandom % 8) == 0, 8'($urandom));
        idle(FRAME + 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
